asym_bram_tdp_rf: RTL and testbench

- Single-clock, true dual-port, read-first RAM with asymmetric port widths.
- Port A is the wide port (one word = RATIO narrow lanes); port B is the narrow port.
- Both ports can read and write the same storage.
- Used as a line/weight buffer: the wide side fills it, the narrow side streams it out element by element. Written so synthesis infers block RAM.

---
 rtl/asym_bram_pkg.sv | 29 ++
 rtl/asym_bram_out_reg.sv | 19 +
 rtl/asym_bram_tdp_rf.sv | 119 +++++++++++
 tb/tb_asym_bram_tdp_rf.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/asym_bram_pkg.sv
// Shared helpers for the asymmetric true dual-port RAM: lane mapping and parameter legality.
package asym_bram_pkg;

    function automatic int unsigned calc_ratio(input int unsigned width_a, input int unsigned width_b);
        return (width_b == 0) ? 0 : width_a / width_b;
    endfunction

    // First narrow word covered by wide word addr_a.
    function automatic int unsigned lane_base(input int unsigned addr_a, input int unsigned ratio);
        return addr_a * ratio;
    endfunction

    function automatic bit params_legal(
        input int unsigned width_a,
        input int unsigned size_a,
        input int unsigned addr_width_a,
        input int unsigned width_b,
        input int unsigned size_b,
        input int unsigned addr_width_b
    );
        if (width_a == 0 || width_b == 0 || size_a == 0 || size_b == 0) return 1'b0;
        if (width_a % width_b != 0) return 1'b0;
        if (size_a * width_a != size_b * width_b) return 1'b0;
        if (addr_width_a < $clog2(size_a) || addr_width_a == 0) return 1'b0;
        if (addr_width_b < $clog2(size_b) || addr_width_b == 0) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/asym_bram_out_reg.sv
// Resettable output pipeline register, one per RAM port, clocked every cycle.
module asym_bram_out_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/asym_bram_tdp_rf.sv
// Single-clock read-first true dual-port RAM, wide port A / narrow port B, little-endian lanes.
// Define ASYM_BRAM_OUT_REG_EN to add an extra output register stage per port (2-cycle read latency).
module asym_bram_tdp_rf
    import asym_bram_pkg::*;
#(
    parameter int unsigned WIDTHA     = 96,
    parameter int unsigned SIZEA      = 2,
    parameter int unsigned ADDRWIDTHA = 1,
    parameter int unsigned WIDTHB     = 16,
    parameter int unsigned SIZEB      = 12,
    parameter int unsigned ADDRWIDTHB = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enaA,
    input  logic                  weA,
    input  logic [ADDRWIDTHA-1:0] addrA,
    input  logic [WIDTHA-1:0]     diA,
    output logic [WIDTHA-1:0]     doA,
    input  logic                  enaB,
    input  logic                  weB,
    input  logic [ADDRWIDTHB-1:0] addrB,
    input  logic [WIDTHB-1:0]     diB,
    output logic [WIDTHB-1:0]     doB
);

    localparam int unsigned RATIO = calc_ratio(WIDTHA, WIDTHB);
    localparam int unsigned MAW   = (SIZEB > 1) ? $clog2(SIZEB) : 1;
    localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (!params_legal(WIDTHA, SIZEA, ADDRWIDTHA, WIDTHB, SIZEB, ADDRWIDTHB)) begin : g_bad_params
        $error("asym_bram_tdp_rf: illegal parameters WIDTHA=%0d SIZEA=%0d WIDTHB=%0d SIZEB=%0d",
               WIDTHA, SIZEA, WIDTHB, SIZEB);
    end

    logic [WIDTHB-1:0] mem [SIZEB];

    logic                          a_in;
    logic                          b_in;
    logic                          a_wr;
    logic                          b_wr;
    logic                          b_hit;
    logic [31:0]                   a_base;
    logic [MAW-1:0]                b_idx;
    logic [RATIO-1:0][WIDTHB-1:0]  di_a_lanes;
    logic [RATIO-1:0][WIDTHB-1:0]  rd_a_lanes;
    logic [WIDTHA-1:0]             rd_a;
    logic [WIDTHB-1:0]             rd_b;

    assign a_in       = 32'(addrA) < SIZEA;
    assign b_in       = 32'(addrB) < SIZEB;
    assign a_base     = lane_base(32'(addrA), RATIO);
    assign b_idx      = MAW'(addrB);
    assign di_a_lanes = diA;

    // A colliding port-B write is dropped up front rather than relying on NBA ordering.
    assign a_wr  = enaA && weA && a_in;
    assign b_hit = a_wr && (32'(addrB) >= a_base) && ((32'(addrB) - a_base) < RATIO);
    assign b_wr  = enaB && weB && b_in && !b_hit;

    always_comb begin
        rd_a_lanes = '0;
        if (a_in) begin
            for (int unsigned k = 0; k < RATIO; k++) begin
                rd_a_lanes[LW'(k)] = mem[MAW'(a_base + k)];
            end
        end
    end

    // Storage is never reset; writes are blocked while rstn is low so contents survive reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (b_wr) begin
                mem[b_idx] <= diB;
            end
            if (a_wr) begin
                for (int unsigned k = 0; k < RATIO; k++) begin
                    mem[MAW'(a_base + k)] <= di_a_lanes[LW'(k)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_a <= '0;
        end else if (enaA) begin
            rd_a <= rd_a_lanes;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_b <= '0;
        end else if (enaB) begin
            rd_b <= b_in ? mem[b_idx] : '0;
        end
    end

`ifdef ASYM_BRAM_OUT_REG_EN
    asym_bram_out_reg #(.WIDTH(WIDTHA)) u_out_reg_a (
        .clk  (clk),
        .rstn (rstn),
        .d    (rd_a),
        .q    (doA)
    );

    asym_bram_out_reg #(.WIDTH(WIDTHB)) u_out_reg_b (
        .clk  (clk),
        .rstn (rstn),
        .d    (rd_b),
        .q    (doB)
    );
`else
    assign doA = rd_a;
    assign doB = rd_b;
`endif

endmodule

// File: tb/tb_asym_bram_tdp_rf.sv
// Directed self-checking bench for asym_bram_tdp_rf (wide 6x16-bit lanes, narrow 16-bit port).
module tb_asym_bram_tdp_rf;

`ifdef ASYM_BRAM_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk;
    logic        rstn;
    logic        enaA;
    logic        weA;
    logic [1:0]  addrA;
    logic [95:0] diA;
    logic [95:0] doA;
    logic        enaB;
    logic        weB;
    logic [3:0]  addrB;
    logic [15:0] diB;
    logic [15:0] doB;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [15:0] exp_b [12] = '{16'h0B0A, 16'h0D0C, 16'h0F0E, 16'h1110, 16'h1312, 16'h1514,
                                16'h1F1E, 16'h2120, 16'h2322, 16'h2524, 16'h2726, 16'h2928};

    asym_bram_tdp_rf #(
        .WIDTHA     (96),
        .SIZEA      (2),
        .ADDRWIDTHA (2),
        .WIDTHB     (16),
        .SIZEB      (12),
        .ADDRWIDTHB (4)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .enaA  (enaA),
        .weA   (weA),
        .addrA (addrA),
        .diA   (diA),
        .doA   (doA),
        .enaB  (enaB),
        .weB   (weB),
        .addrB (addrB),
        .diB   (diB),
        .doB   (doB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_b(input logic [3:0] a, input logic [15:0] exp, input string tag);
        enaB  = 1'b1;
        weB   = 1'b0;
        addrB = a;
        tick();
        enaB = 1'b0;
        repeat (LAT - 1) tick();
        chk(tag, 96'(doB), 96'(exp));
    endtask

    task automatic rd_a(input logic [1:0] a, input logic [95:0] exp, input string tag);
        enaA  = 1'b1;
        weA   = 1'b0;
        addrA = a;
        tick();
        enaA = 1'b0;
        repeat (LAT - 1) tick();
        chk(tag, doA, exp);
    endtask

    initial begin
        rstn = 1'b0; enaA = 1'b0; weA = 1'b0; addrA = '0; diA = '0;
        enaB = 1'b0; weB = 1'b0; addrB = '0; diB = '0;
        tick();
        chk("reset_doA", doA, 96'h0);
        chk("reset_doB", 96'(doB), 96'h0);
        rstn = 1'b1;
        tick();

        // Wide write, narrow read
        enaA = 1'b1; weA = 1'b1; addrA = 2'd0; diA = 96'h15141312_11100F0E_0D0C0B0A;
        tick();
        addrA = 2'd1; diA = 96'h29282726_25242322_21201F1E;
        tick();
        enaA = 1'b0; weA = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rd_b(4'(i), exp_b[i], $sformatf("w2n_b%0d", i));
        end
        rd_a(2'd1, 96'h29282726_25242322_21201F1E, "w2n_a1");

        // Narrow write, wide read
        for (int i = 0; i < 6; i++) begin
            enaB = 1'b1; weB = 1'b1; addrB = 4'(i); diB = 16'h0100 + 16'(i);
            tick();
        end
        enaB = 1'b0; weB = 1'b0;
        rd_a(2'd0, 96'h0105_0104_0103_0102_0101_0100, "n2w_a0");

        // Read-first across ports
        enaB = 1'b1; weB = 1'b1; addrB = 4'd3; diB = 16'hAAAA;
        tick();
        diB = 16'h5555; enaA = 1'b1; weA = 1'b0; addrA = 2'd0;
        tick();
        enaA = 1'b0; enaB = 1'b0; weB = 1'b0;
        repeat (LAT - 1) tick();
        chk("rf_doB_old", 96'(doB), 96'hAAAA);
        chk("rf_doA_lane3", 96'(doA[63:48]), 96'hAAAA);
        chk("rf_doA_full", doA, 96'h0105_0104_AAAA_0102_0101_0100);
        rd_b(4'd3, 16'h5555, "rf_b3_new");

        // Same-word write collision: port A wins
        enaA = 1'b1; weA = 1'b1; addrA = 2'd1; diA = {6{16'h1111}};
        enaB = 1'b1; weB = 1'b1; addrB = 4'd7; diB = 16'h2222;
        tick();
        enaA = 1'b0; weA = 1'b0; enaB = 1'b0; weB = 1'b0;
        repeat (LAT - 1) tick();
        chk("col_doB_old", 96'(doB), 96'h2120);
        chk("col_doA_old", doA, 96'h29282726_25242322_21201F1E);
        rd_b(4'd7, 16'h1111, "col_b7");
        rd_b(4'd6, 16'h1111, "col_b6");
        rd_a(2'd1, {6{16'h1111}}, "col_a1");

        // Enable low: output holds, write suppressed
        rd_b(4'd2, 16'h0102, "en_b2");
        enaB = 1'b0; weB = 1'b1; addrB = 4'd5; diB = 16'hDEAD;
        tick();
        addrB = 4'd9;
        tick();
        weB = 1'b0;
        chk("en_hold", 96'(doB), 96'h0102);
        rd_b(4'd5, 16'h0105, "en_nowrite");

        // Out of range
        rd_b(4'd13, 16'h0000, "oor_b13");
        rd_b(4'd12, 16'h0000, "oor_b12");
        enaA = 1'b1; weA = 1'b1; addrA = 2'd2; diA = '1;
        tick();
        enaA = 1'b0; weA = 1'b0;
        repeat (LAT - 1) tick();
        chk("oor_a2_read", doA, 96'h0);
        rd_a(2'd0, 96'h0105_0104_5555_0102_0101_0100, "oor_a0_intact");
        rd_a(2'd1, {6{16'h1111}}, "oor_a1_intact");
        rd_a(2'd3, 96'h0, "oor_a3");

        // Reset mid-operation
        rd_b(4'd1, 16'h0101, "pre_rst_b1");
        rd_a(2'd0, 96'h0105_0104_5555_0102_0101_0100, "pre_rst_a0");
        enaA = 1'b1; weA = 1'b1; addrA = 2'd0; diA = '1;
        enaB = 1'b1; weB = 1'b1; addrB = 4'd3; diB = 16'h0000;
        rstn = 1'b0;
        #1;
        chk("rst_async_doA", doA, 96'h0);
        chk("rst_async_doB", 96'(doB), 96'h0);
        tick();
        chk("rst_hold_doA", doA, 96'h0);
        chk("rst_hold_doB", 96'(doB), 96'h0);
        enaA = 1'b0; weA = 1'b0; weB = 1'b0;
        enaB = 1'b1; addrB = 4'd3;
        rstn = 1'b1;
        tick();
        enaB = 1'b0;
`ifdef ASYM_BRAM_OUT_REG_EN
        chk("post_rst_lat1", 96'(doB), 96'h0);
        tick();
`endif
        chk("post_rst_b3", 96'(doB), 96'h5555);
        rd_a(2'd0, 96'h0105_0104_5555_0102_0101_0100, "post_rst_a0");
        rd_a(2'd1, {6{16'h1111}}, "post_rst_a1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
